posit8_quire_accumulator: RTL

- Sequential accumulate-and-pack stage directly downstream of the posit8 operand unpacking/multiply unit.
- Consumes one decoded product per handshake (sign, scale factor, 2.10 mantissa, NaR flag) and aligns it into a 32-bit two's-complement quire.
- On the last term of a dot product, converts the quire to a posit<8,0> result with round-to-nearest-even and presents it on a valid/ready output.

---
 rtl/posit8_pkg.sv | 21 ++
 rtl/quire_to_posit8.sv | 73 +++++++
 rtl/posit8_quire_accumulator.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/posit8_pkg.sv
// Shared constants and FSM state encoding for the posit8 quire datapath.
package posit8_pkg;

  localparam int QW         = 32;
  localparam int FRAC_LSB   = 16;
  localparam int ALIGN_BIAS = 6;

  localparam logic [7:0] POSIT_NAR    = 8'h80;
  localparam logic [7:0] POSIT_MAXPOS = 8'h7F;
  localparam logic [7:0] POSIT_MINPOS = 8'h01;
  localparam logic [7:0] POSIT_ZERO   = 8'h00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    DRAIN   = 3'd2,
    CONVERT = 3'd3,
    HOLD    = 3'd4
  } acc_state_e;

endpackage

// File: rtl/quire_to_posit8.sv
// Combinational Q16.16 quire to posit<8,0> converter: leading-one detect,
// regime/fraction packing and round-to-nearest-even with saturation.
module quire_to_posit8
  import posit8_pkg::*;
(
  input  logic [QW-1:0] quire,
  input  logic          sticky,
  input  logic          nar,
  output logic [7:0]    posit8
);

  logic              neg_s;
  logic [QW-1:0]     mag_s;
  logic [4:0]        lead_s;
  logic              found_s;
  logic signed [6:0] k_s;
  logic [6:0]        kabs_s;
  logic [6:0]        len_s;
  logic [63:0]       regime_s;
  logic [63:0]       frac_s;
  logic [63:0]       body_s;
  logic              guard_s;
  logic              rnd_sticky_s;
  logic [7:0]        rounded_s;
  logic [7:0]        mag8_s;

  // Body is regime+terminator followed by the bits below the leading one,
  // left-aligned so bit 63..57 are the 7 posit bits and bit 56 is the guard.
  always_comb begin
    neg_s   = quire[QW-1];
    mag_s   = neg_s ? (~quire + 32'd1) : quire;
    lead_s  = 5'd0;
    found_s = 1'b0;
    for (int i = 0; i < QW; i++) begin
      lead_s  = mag_s[i] ? 5'(i) : lead_s;
      found_s = found_s | mag_s[i];
    end
    k_s    = signed'({2'b00, lead_s}) - signed'(7'(FRAC_LSB));
    kabs_s = k_s[6] ? 7'(-k_s) : 7'(k_s);
    if (k_s[6]) begin
      regime_s = 64'h8000_0000_0000_0000 >> kabs_s;
      len_s    = kabs_s + 7'd1;
    end else begin
      regime_s = ~(64'hFFFF_FFFF_FFFF_FFFF >> (kabs_s + 7'd1));
      len_s    = kabs_s + 7'd2;
    end
    frac_s       = {32'd0, mag_s} << (7'd64 - {2'b00, lead_s});
    body_s       = regime_s | (frac_s >> len_s);
    guard_s      = body_s[56];
    rnd_sticky_s = (|body_s[55:0]) | sticky;
    rounded_s    = {1'b0, body_s[63:57]} + {7'd0, guard_s & (rnd_sticky_s | body_s[57])};

    mag8_s = rounded_s;
    if (!found_s) begin
      mag8_s = POSIT_MINPOS;
    end else if (k_s >= 7'sd6) begin
      mag8_s = POSIT_MAXPOS;
    end else if (k_s <= -7'sd7) begin
      mag8_s = POSIT_MINPOS;
    end else begin
      mag8_s = rounded_s;
    end

    if (nar) begin
      posit8 = POSIT_NAR;
    end else if (!found_s && !sticky) begin
      posit8 = POSIT_ZERO;
    end else begin
      posit8 = neg_s ? (~mag8_s + 8'd1) : mag8_s;
    end
  end

endmodule

// File: rtl/posit8_quire_accumulator.sv
// Aligns decoded posit8 products into a Q16.16 quire and, on the last term of
// a dot product, converts the quire to posit<8,0> behind a valid/ready port.
module posit8_quire_accumulator
  import posit8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        prod_sign,
  input  logic [4:0]  prod_sf,
  input  logic [11:0] prod_mant,
  input  logic        prod_zero,
  input  logic        prod_nar,
  input  logic        acc_last,
  input  logic        acc_clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  posit_out,
  output logic        quire_ovf
);

  acc_state_e        state_r, state_s;
  logic              accum_phase_s, accept_s, clear_s, hand_s;
  logic signed [5:0] shift_s;
  logic [4:0]        rsh_s;
  logic [QW-1:0]     mag_term_s, term_s;
  logic              lost_s;
  logic              s0_valid_r, s0_lost_r, s0_nar_r;
  logic [QW-1:0]     s0_term_r;
  logic [QW-1:0]     quire_r;
  logic              sticky_lsb_r, nar_r, quire_ovf_r;
  logic [QW:0]       sum_s;
  logic              sum_ovf_s;
  logic              in_ready_r, out_valid_r;
  logic [7:0]        posit_out_r, conv_s;

  assign accum_phase_s = (state_r == IDLE) || (state_r == ACCUM);
  assign accept_s      = in_valid & in_ready_r;
  assign clear_s       = acc_clear & accum_phase_s;
  assign hand_s        = out_valid_r & out_ready;
  assign sum_s         = {quire_r[QW-1], quire_r} + {s0_term_r[QW-1], s0_term_r};
  assign sum_ovf_s     = sum_s[QW] ^ sum_s[QW-1];

  // Scale the 2.10 mantissa onto the quire grid; right shifts record lost bits.
  always_comb begin
    shift_s    = signed'({prod_sf[4], prod_sf}) + signed'(6'(ALIGN_BIAS));
    rsh_s      = 5'd0;
    lost_s     = 1'b0;
    mag_term_s = {20'd0, prod_mant} << shift_s[4:0];
    if (shift_s[5]) begin
      rsh_s      = 5'(-shift_s);
      mag_term_s = {20'd0, prod_mant} >> rsh_s;
      lost_s     = |(prod_mant & ~(12'hFFF << rsh_s));
    end else begin
      rsh_s      = 5'd0;
    end
    if (prod_zero || prod_nar) begin
      term_s = {QW{1'b0}};
      lost_s = 1'b0;
    end else if (prod_sign) begin
      term_s = ~mag_term_s + 32'd1;
    end else begin
      term_s = mag_term_s;
    end
  end

  // Next-state logic for the accumulate / drain / convert / hold sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (clear_s) begin
          state_s = IDLE;
        end else if (accept_s && acc_last) begin
          state_s = DRAIN;
        end else if (accept_s) begin
          state_s = ACCUM;
        end else begin
          state_s = state_r;
        end
      end
      DRAIN:   state_s = CONVERT;
      CONVERT: state_s = HOLD;
      HOLD: begin
        if (hand_s) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  quire_to_posit8 u_conv (
    .quire  (quire_r),
    .sticky (sticky_lsb_r),
    .nar    (nar_r),
    .posit8 (conv_s)
  );

  // Alignment register; a clear discards whatever it holds or would capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_r <= 1'b0;
      s0_term_r  <= {QW{1'b0}};
      s0_lost_r  <= 1'b0;
      s0_nar_r   <= 1'b0;
    end else begin
      s0_valid_r <= accept_s & ~clear_s;
      if (accept_s) begin
        s0_term_r <= term_s;
        s0_lost_r <= lost_s;
        s0_nar_r  <= prod_nar;
      end
    end
  end

  // Quire and sticky flags; emptied once the result has been converted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quire_r      <= {QW{1'b0}};
      sticky_lsb_r <= 1'b0;
      nar_r        <= 1'b0;
    end else if (clear_s || (state_r == CONVERT)) begin
      quire_r      <= {QW{1'b0}};
      sticky_lsb_r <= 1'b0;
      nar_r        <= 1'b0;
    end else if (s0_valid_r) begin
      quire_r      <= sum_s[QW-1:0];
      sticky_lsb_r <= sticky_lsb_r | s0_lost_r;
      nar_r        <= nar_r | s0_nar_r | sum_ovf_s;
    end
  end

  // Overflow flag is kept until the result is taken so HOLD still shows it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quire_ovf_r <= 1'b0;
    end else if (clear_s || hand_s) begin
      quire_ovf_r <= 1'b0;
    end else if (s0_valid_r && sum_ovf_s) begin
      quire_ovf_r <= 1'b1;
    end
  end

  // State and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      posit_out_r <= POSIT_ZERO;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE) || (state_s == ACCUM);
      out_valid_r <= (state_s == HOLD);
      if (state_r == CONVERT) begin
        posit_out_r <= conv_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign posit_out = posit_out_r;
  assign quire_ovf = quire_ovf_r;

endmodule
